multi_edge_detector: RTL
========================

// Module: multi_edge_detector
// PURPOSE
//  Multi-channel, parametrised edge detector for asynchronous level inputs.
//  Per channel: synchroniser, debounce filter, rise/fall pulses, per-channel mode
//  select, sticky pending flag and saturating event counter.
//  Aggregated irq_o feeds the interrupt controller; pulses feed local sequencers.
// PARAMETERS
//  NUM_CH       8  number of independent input channels (>=1)
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  DEBOUNCE     4  consecutive stable cycles before filtered level changes; 0 or 1 = no filter
//  CNT_W        8  width of per-channel event counter (saturating)
// PORTS
//  clk        in   1           single clock; all logic on posedge
//  reset      in   1           synchronous, active-high reset
//  a_i        in   NUM_CH      asynchronous level inputs, bit i = channel i
//  mode_i     in   2*NUM_CH    per-channel mode, edge_mode_e: NONE/RISE/FALL/BOTH
//  clear_i    in   NUM_CH      pulse: clears pend_o[i] and count of channel i
//  rise_o     out  NUM_CH      1-cycle pulse on filtered rising edge (mode-independent)
//  fall_o     out  NUM_CH      1-cycle pulse on filtered falling edge (mode-independent)
//  event_o    out  NUM_CH      1-cycle pulse on edge qualified by mode_i
//  pend_o     out  NUM_CH      sticky flag, set by event_o, cleared by clear_i
//  cnt_o      out  CNT_W*NUM_CH  saturating qualified-event count, channel i at [i*CNT_W +: CNT_W]
//  irq_o      out  1           OR of pend_o
// BEHAVIOUR
//  Reset: sync flops, filtered level, debounce counters, all outputs = 0.
//   A channel high through reset reports exactly one rising edge after release.
//  Sync: a_i[i] sampled at posedge N appears at sync output after posedge N+SYNC_STAGES-1.
//  Debounce:
//   - stab_cnt counts cycles where sync output != filtered level.
//   - Returns to 0 the cycle they match (a glitch restarts the count).
//   - Filtered level toggles at the edge where the mismatch has persisted max(DEBOUNCE,1) cycles.
//   - stab_cnt width is $clog2(DEBOUNCE+1); stab_cnt never wraps.
//  Latency: a clean transition sampled at posedge N gives rise_o/fall_o high in the cycle
//   after posedge N+SYNC_STAGES+max(DEBOUNCE,1)-1.
//   Defaults: N+5. Pulses are registered, exactly 1 cycle wide.
//  Mode: event_o = (rise & mode in {RISE,BOTH}) | (fall & mode in {FALL,BOTH}).
//   mode_i is sampled in the same cycle the edge is registered.
//   A mode change never alters existing pend_o or cnt_o.
//  Pending: pend_o[i] <= event | (pend_o[i] & ~clear_i[i]).
//   Simultaneous event and clear: pending stays 1 (set wins, no event lost).
//  Counter:
//   - increments by 1 per qualified event and saturates at 2^CNT_W-1 (never wraps).
//   - clear_i zeroes it; simultaneous clear and event gives 1.
//  irq_o: combinational OR of pend_o registers; no extra latency.
//  Reset mid-operation: pending debounce aborted; no pulse emitted in the reset cycle or the cycle after.
//  Channels fully independent; no cross-channel priority or arbitration.
// STRUCTURE
//  edge_det_pkg: typedef enum logic [1:0] edge_mode_e {EDGE_NONE=0, EDGE_RISE=1,
//   EDGE_FALL=2, EDGE_BOTH=3}.
//  Sub-module edge_det_chan: one channel (sync, debounce, detect, pend, counter).
//  Top instantiates NUM_CH of them via generate and ORs pend into irq_o.
// TESTING
//  1 DEBOUNCE=4, mode=BOTH, a_i[0] 0->1 held 10 cycles at posedge 10
//    -> rise_o[0]/event_o[0] high only in the cycle after posedge 15; pend_o[0]=1; cnt=1; irq_o=1.
//  2 Glitches of 1, 2, 3 cycles high on ch1 (DEBOUNCE=4)
//    -> no rise_o/fall_o ever; cnt stays 0. A 4-cycle pulse -> one rise then one fall.
//  3 mode=RISE on ch2, toggle 0->1->0
//    -> rise_o and fall_o both pulse, event_o only on rise; cnt=1.
//    Switch to NONE -> pulses continue, event_o and cnt frozen.
//  4 clear_i[3] asserted in the same cycle as a qualified event
//    -> pend_o[3]=1 and cnt=1 next cycle. Clear alone -> pend_o[3]=0, cnt=0, irq_o=0.
//  5 CNT_W=3, 10 qualified events on ch0 -> cnt saturates at 7 and holds; clear -> 0.
//  6 Hold a_i=all-ones through reset, then release
//    -> exactly one rise pulse per channel; reset asserted mid-debounce -> no pulse.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
//   edge_mode_e : per-channel qualification mode (NONE/RISE/FALL/BOTH)
//   mode_rise() / mode_fall() : decode whether a mode accepts a given edge
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

    function automatic logic mode_rise(input edge_mode_e m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

    function automatic logic mode_fall(input edge_mode_e m);
        return (m == EDGE_FALL) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, debounce filter, rise/fall pulse
// generation, mode-qualified event, sticky pending flag, saturating counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   a          : asynchronous level input
//   mode       : edge qualification mode
//   clear      : pulse, clears pend and cnt
//   rise, fall : 1-cycle pulses on filtered edges (mode-independent)
//   evt        : 1-cycle pulse on a mode-qualified edge
//   pend       : sticky flag set by evt
//   cnt        : saturating count of qualified events
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  edge_mode_e       mode,
    input  logic             clear,
    output logic             rise,
    output logic             fall,
    output logic             evt,
    output logic             pend,
    output logic [CNT_W-1:0] cnt
);

    // DEBOUNCE of 0 or 1 both mean "accept after one mismatching cycle".
    localparam int DB   = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
    localparam int SC_W = $clog2(DB + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DB - 1);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync;
    logic                   filt;
    logic [SC_W-1:0]        stab_cnt;
    logic                   mismatch;
    logic                   toggle;

    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], a};
    end

    assign sync     = sync_pipe[SYNC_STAGES-1];
    assign mismatch = sync ^ filt;
    // Toggle on the edge that completes DB consecutive mismatching cycles;
    // stab_cnt is cleared there, so it never reaches DB and cannot wrap.
    assign toggle   = mismatch && (stab_cnt == SC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            filt     <= 1'b0;
            stab_cnt <= '0;
        end else if (toggle) begin
            filt     <= sync;
            stab_cnt <= '0;
        end else if (mismatch) begin
            stab_cnt <= stab_cnt + SC_W'(1);
        end else begin
            stab_cnt <= '0;
        end
    end

    // Pulses are registered on the same edge the filtered level flips.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
            evt  <= 1'b0;
        end else begin
            rise <= toggle & sync;
            fall <= toggle & ~sync;
            evt  <= toggle & ((sync & mode_rise(mode)) | (~sync & mode_fall(mode)));
        end
    end

    // Pending and counter follow the registered event; set beats clear so a
    // coincident event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            pend <= evt | (pend & ~clear);
            if (clear)              cnt <= CNT_W'(evt);
            else if (evt && !(&cnt)) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: NUM_CH independent edge_det_chan instances
// plus an aggregated interrupt (OR of all pending flags).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   a_i        : asynchronous level inputs, bit i = channel i
//   mode_i     : per-channel edge_mode_e, channel i at [2*i +: 2]
//   clear_i    : per-channel clear pulse for pend_o / cnt_o
//   rise_o, fall_o, event_o : per-channel 1-cycle pulses
//   pend_o     : per-channel sticky pending flags
//   cnt_o      : per-channel saturating counts, channel i at [i*CNT_W +: CNT_W]
//   irq_o      : OR of pend_o
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       a_i,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0]       clear_i,
    output logic [NUM_CH-1:0]       rise_o,
    output logic [NUM_CH-1:0]       fall_o,
    output logic [NUM_CH-1:0]       event_o,
    output logic [NUM_CH-1:0]       pend_o,
    output logic [CNT_W*NUM_CH-1:0] cnt_o,
    output logic                    irq_o
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .a     (a_i[i]),
            .mode  (edge_mode_e'(mode_i[2*i +: 2])),
            .clear (clear_i[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i]),
            .evt   (event_o[i]),
            .pend  (pend_o[i]),
            .cnt   (cnt_o[i*CNT_W +: CNT_W])
        );
    end

    assign irq_o = |pend_o;

endmodule
